// File: rtl/flex_counter_multi.sv
// NUM_CH independent up/down counters with clear, load and a live rollover value.
// Optional sticky wrap status per channel is built only when FLEX_CNT_STICKY_EN is defined.
module flex_counter_multi #(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned NUM_CH       = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              count_enable,
  input  logic [NUM_CH-1:0]              up_down,
  input  logic [NUM_CH-1:0]              clear,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
  input  logic [NUM_CH-1:0]              wrap_ack,
  output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
  output logic [NUM_CH-1:0]              rollover_flag,
  output logic [NUM_CH-1:0]              wrap_sticky
);

  localparam int unsigned W = NUM_CNT_BITS;

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] roll;
    logic         wrap;

    assign roll = rollover_val[g*W +: W];

    // Priority clear > load > enable > hold; R == 0 pins the count at 0 and wraps every step.
    always_comb begin
      cnt_d = cnt_q;
      wrap  = 1'b0;
      if (clear[g]) begin
        cnt_d = '0;
      end else if (load[g]) begin
        cnt_d = load_val[g*W +: W];
      end else if (count_enable[g]) begin
        if (roll == '0) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else if (up_down[g]) begin
          if (cnt_q >= roll) begin
            cnt_d = W'(1);
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end else begin
          if (cnt_q <= W'(1)) begin
            cnt_d = roll;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q - W'(1);
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign count_out[g*W +: W] = cnt_q;
    assign rollover_flag[g]    = up_down[g] ? (cnt_q >= roll)
                                            : ((cnt_q <= W'(1)) || (roll == '0));

`ifdef FLEX_CNT_STICKY_EN
    logic sticky_q;
    logic sticky_d;

    // A wrap on the same edge as an ack keeps the status set.
    always_comb begin
      sticky_d = sticky_q;
      if (wrap) begin
        sticky_d = 1'b1;
      end else if (wrap_ack[g]) begin
        sticky_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sticky_q <= 1'b0;
      end else begin
        sticky_q <= sticky_d;
      end
    end

    assign wrap_sticky[g] = sticky_q;
`else
    logic unused_wrap;
    assign unused_wrap    = wrap ^ wrap_ack[g];
    assign wrap_sticky[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_flex_counter_multi.sv
// Directed bench for flex_counter_multi (NUM_CNT_BITS=4, NUM_CH=2).
module tb_flex_counter_multi;

  localparam int unsigned W  = 4;
  localparam int unsigned NC = 2;
`ifdef FLEX_CNT_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   count_enable, up_down, clear, load, wrap_ack;
  logic [NC*W-1:0] load_val, rollover_val;
  logic [NC*W-1:0] count_out;
  logic [NC-1:0]   rollover_flag, wrap_sticky;

  int n_total = 0;
  int n_pass  = 0;

  flex_counter_multi #(.NUM_CNT_BITS(W), .NUM_CH(NC)) dut (
    .clk          (clk),
    .rst          (rst),
    .count_enable (count_enable),
    .up_down      (up_down),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .rollover_val (rollover_val),
    .wrap_ack     (wrap_ack),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_sticky  (wrap_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int up_seq [7] = '{1, 2, 3, 4, 5, 1, 2};
  int dn_seq [5] = '{1, 3, 2, 1, 3};

  initial begin
    rst = 1'b1; count_enable = '0; up_down = '0; clear = '0; load = '0;
    wrap_ack = '0; load_val = '0; rollover_val = '0;
    tick(); tick();
    check("reset_count", 32'(count_out), 32'h0);
    check("reset_sticky", 32'(wrap_sticky), 32'h0);
    rst = 1'b0;

    // Up count on ch0 with R=5
    rollover_val[3:0] = 4'd5;
    up_down[0] = 1'b1;
    count_enable[0] = 1'b1;
    #1;
    check("up_start", 32'(count_out[3:0]), 32'd0);
    check("up_start_flag", 32'(rollover_flag[0]), 32'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("up_cnt%0d", i), 32'(count_out[3:0]), 32'(up_seq[i]));
      check($sformatf("up_flag%0d", i), 32'(rollover_flag[0]), 32'(up_seq[i] == 5));
      check($sformatf("up_sticky%0d", i), 32'(wrap_sticky[0]), 32'(STICKY && i >= 5));
    end
    count_enable[0] = 1'b0;
    check("iso_ch1_idle", 32'(count_out[7:4]), 32'd0);

    // Down count on ch1 with R=3 after loading 2
    rollover_val[7:4] = 4'd3;
    load_val[7:4] = 4'd2;
    load[1] = 1'b1;
    tick();
    load[1] = 1'b0;
    check("dn_load", 32'(count_out[7:4]), 32'd2);
    check("dn_load_flag", 32'(rollover_flag[1]), 32'd0);
    count_enable[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("dn_cnt%0d", i), 32'(count_out[7:4]), 32'(dn_seq[i]));
      check($sformatf("dn_flag%0d", i), 32'(rollover_flag[1]), 32'(dn_seq[i] == 1));
      check($sformatf("dn_sticky%0d", i), 32'(wrap_sticky[1]), 32'(STICKY && i >= 1));
      check($sformatf("iso_ch0_%0d", i), 32'(count_out[3:0]), 32'd2);
    end

    // Sticky: ack alone clears, wrap with ack keeps it set
    count_enable[1] = 1'b0;
    wrap_ack[1] = 1'b1;
    tick();
    check("ack_clear1", 32'(wrap_sticky[1]), 32'd0);
    check("ack_hold_cnt", 32'(count_out[7:4]), 32'd3);
    wrap_ack[1] = 1'b0;
    count_enable[1] = 1'b1;
    tick(); tick();
    check("pre_wrap_cnt", 32'(count_out[7:4]), 32'd1);
    wrap_ack[1] = 1'b1;
    tick();
    check("wrap_ack_cnt", 32'(count_out[7:4]), 32'd3);
    check("wrap_ack_set_wins", 32'(wrap_sticky[1]), 32'(STICKY));
    count_enable[1] = 1'b0;
    tick();
    check("ack_clear2", 32'(wrap_sticky[1]), 32'd0);
    wrap_ack[1] = 1'b0;

    // Priority on ch0: clear beats load and enable
    load_val[3:0] = 4'd7;
    clear[0] = 1'b1; load[0] = 1'b1; count_enable[0] = 1'b1;
    tick();
    check("prio_clear", 32'(count_out[3:0]), 32'd0);
    clear[0] = 1'b0; count_enable[0] = 1'b0;
    tick();
    check("prio_load_above_r", 32'(count_out[3:0]), 32'd7);
    load[0] = 1'b0;

    // Live R change: count 6, R lowered from 10 to 4
    rollover_val[3:0] = 4'd10;
    load_val[3:0] = 4'd6; load[0] = 1'b1;
    tick();
    load[0] = 1'b0;
    check("live_cnt6", 32'(count_out[3:0]), 32'd6);
    check("live_flag_before", 32'(rollover_flag[0]), 32'd0);
    rollover_val[3:0] = 4'd4;
    #1;
    check("live_flag_now", 32'(rollover_flag[0]), 32'd1);
    count_enable[0] = 1'b1;
    tick();
    check("live_wrap", 32'(count_out[3:0]), 32'd1);

    // R = 0 degenerate: enabled step forces 0, flag high in both modes
    rollover_val[3:0] = 4'd0;
    tick();
    check("r0_cnt", 32'(count_out[3:0]), 32'd0);
    check("r0_flag_up", 32'(rollover_flag[0]), 32'd1);
    up_down[0] = 1'b0;
    #1;
    check("r0_flag_dn", 32'(rollover_flag[0]), 32'd1);

    // Reset mid-count overrides load and enable
    up_down[0] = 1'b1;
    rollover_val[3:0] = 4'd9;
    tick(); tick();
    check("pre_rst_ch0", 32'(count_out[3:0]), 32'd2);
    check("pre_rst_ch1", 32'(count_out[7:4]), 32'd3);
    rst = 1'b1; load = 2'b11; load_val = 8'h55; count_enable = 2'b11;
    tick();
    check("rst_mid_count", 32'(count_out), 32'h0);
    check("rst_mid_sticky", 32'(wrap_sticky), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/flex_counter_multi.md
# flex_counter_multi

Parametrised, multi-channel successor to the team's single-channel flex counter. It provides NUM_CH independent counters of NUM_CNT_BITS each. Each channel has its own enable, up/down direction, synchronous clear, parallel load and programmable rollover value. It serves timer, baud and bit-count generation across the datapath, and one instance replaces several single-channel counters.

## Interface
Parameters:
- NUM_CNT_BITS, 4: width of each channel's counter.
- NUM_CH, 2: number of independent channels; channel i occupies bits [i*NUM_CNT_BITS +: NUM_CNT_BITS] of every packed bus.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- count_enable  input  NUM_CH  per-channel advance request.
- up_down  input  NUM_CH  per-channel direction; 1 = count up, 0 = count down.
- clear  input  NUM_CH  per-channel synchronous clear to 0.
- load  input  NUM_CH  per-channel synchronous load of load_val.
- load_val  input  NUM_CH*NUM_CNT_BITS  per-channel load value.
- rollover_val  input  NUM_CH*NUM_CNT_BITS  per-channel terminal value, sampled live every cycle.
- wrap_ack  input  NUM_CH  per-channel clear for wrap_sticky.
- count_out  output  NUM_CH*NUM_CNT_BITS  per-channel registered count.
- rollover_flag  output  NUM_CH  per-channel terminal indicator, combinational from count_out, rollover_val and up_down.
- wrap_sticky  output  NUM_CH  per-channel sticky wrap status.

## Operation
- Reset: count_out = 0 and wrap_sticky = 0 on every channel. rst overrides all other inputs.
- Channels are fully independent. There is no cross-channel interaction.
- Per-channel priority, highest first: clear, load, count_enable, hold.
  - clear: count is set to 0.
  - load: count is set to load_val. Values above rollover_val are accepted as-is.
- Up-count step with count_enable=1 and R = rollover_val:
  - If count >= R, next count = 1. This is a wrap event. The >= covers rollover_val being lowered mid-count.
  - Otherwise, next count = count + 1.
- Down-count step with count_enable=1:
  - If count <= 1, next count = R. This is a wrap event.
  - Otherwise, next count = count - 1.
- R = 0, degenerate case: enabled steps force count to 0, and a wrap event is flagged every enabled cycle.
- rollover_flag[i]:
  - Up mode: 1 when count >= R.
  - Down mode: 1 when count <= 1, or when R = 0.
- Changing up_down takes effect on the next enabled step. No reset of the count occurs.
- Arithmetic is modulo 2^NUM_CNT_BITS, but wrap logic prevents any natural overflow or underflow.
- A wrap event is defined only for an enable step. Clear and load never generate wrap events.

## Timing
- count_out updates one clock after the qualifying input is sampled.
- rollover_flag has zero latency relative to count_out and rollover_val. There is no extra register.
- wrap_sticky sets on the clock edge that performs the wrap step, so it is visible in the same cycle as the new count.
- Simultaneous wrap event and wrap_ack on the same channel: set wins, and wrap_sticky stays 1.
- rst asserted mid-count: the next edge yields all outputs 0, regardless of any enable, load or clear in that cycle.

## Configuration
- FLEX_CNT_STICKY_EN:
  - Defined: wrap_sticky register is built, with set/ack behaviour as above.
  - Undefined: wrap_sticky is driven constant 0, wrap_ack is ignored, and no sticky flops are inferred.
- Counting and rollover_flag are identical in both builds.

## Test plan
- Reset, then up-count, NUM_CNT_BITS=4, R=5, ch0 enabled continuously:
  - count_out sequence is 0,1,2,3,4,5,1,2.
  - rollover_flag is high only while the count is 5.
  - wrap_sticky[0] rises with the first 1 after 5.
- Down-count, ch1, R=3, load_val=2, load pulse, then enable:
  - count_out sequence is 2,1,3,2,1,3.
  - rollover_flag is high at each count of 1.
- Priority, one cycle with clear=1, load=1 (load_val=7) and enable=1:
  - count_out is 0.
  - The next cycle with only load=1 gives 7.
- Live R change, count=6 in up mode, R lowered to 4:
  - rollover_flag asserts immediately.
  - The next enabled step gives 1.
- Sticky, with FLEX_CNT_STICKY_EN defined:
  - A wrap and wrap_ack in the same cycle keep wrap_sticky at 1.
  - wrap_ack alone on the next cycle clears it to 0.
  - With the macro undefined, wrap_sticky stays 0 throughout.
- Channel isolation and reset: ch0 counting with ch1 held.
  - ch1 count_out stays unchanged.
  - Asserting rst mid-sequence zeroes all counts on the next edge.
